// File: rtl/parking_exit_controller.sv
// Exit gate controller: verifies a two-field payment code, raises the barrier,
// confirms the exit and keeps the lot occupancy count with its lamp/segment outputs.
module parking_exit_controller #(
  parameter int unsigned CAPACITY     = 8,
  parameter int unsigned WAIT_CYCLES  = 4,
  parameter int unsigned OPEN_TIMEOUT = 8,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [1:0]  PAY_CODE     = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_exit,
  input  logic       sense_clear,
  input  logic       pay_valid,
  input  logic [1:0] pay_1,
  input  logic [1:0] pay_2,
  input  logic       car_entered,
  output logic       gate_open,
  output logic       green_light,
  output logic       red_light,
  output logic       alarm,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2,
  output logic       exit_done,
  output logic [3:0] count_cars,
  output logic [3:0] space_available
);

  typedef enum logic [2:0] {S_IDLE, S_VERIFY, S_OPEN, S_DENY, S_LOCK} state_t;

  localparam logic [3:0] CAP       = 4'(CAPACITY);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] OPEN_LAST = 4'(OPEN_TIMEOUT - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_P   = 7'b1110011;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_G   = 7'b1111101;
  localparam logic [6:0] SEG_O   = 7'b0111111;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_S   = 7'b1101101;

  state_t     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [1:0] retry_q, retry_d;
  logic [3:0] count_q, count_d;
  logic [3:0] space_q;
  logic       exit_q;
  logic       gate_q, green_q, red_q, alarm_q;
  logic       gate_d, green_d, red_d, alarm_d;
  logic [6:0] hex1_q, hex2_q, hex1_d, hex2_d;

  logic pay_ok;
  logic confirmed_exit;
  logic inc, dec;

  assign pay_ok         = (pay_1 == PAY_CODE) && (pay_2 == PAY_CODE);
  assign confirmed_exit = (state_q == S_OPEN) && sense_clear;
  assign inc            = car_entered && (count_q < CAP);
  assign dec            = confirmed_exit && (count_q != 4'd0);

  // State register; outputs are registered from the next-state decode so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= 4'd0;
      retry_q <= 2'd0;
      count_q <= 4'd0;
      space_q <= CAP;
      exit_q  <= 1'b0;
      gate_q  <= 1'b0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      alarm_q <= 1'b0;
      hex1_q  <= SEG_OFF;
      hex2_q  <= SEG_OFF;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      retry_q <= retry_d;
      count_q <= count_d;
      space_q <= CAP - count_d;
      exit_q  <= confirmed_exit;
      gate_q  <= gate_d;
      green_q <= green_d;
      red_q   <= red_d;
      alarm_q <= alarm_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

  // Simultaneous entry and exit cancel; both directions saturate.
  always_comb begin
    count_d = count_q;
    if (inc && !dec)      count_d = count_q + 4'd1;
    else if (dec && !inc) count_d = count_q - 4'd1;
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: begin
        if (sense_exit && (count_q != 4'd0)) begin
          state_d = S_VERIFY;
          tcnt_d  = 4'd0;
        end
      end
      S_VERIFY: begin
        if (!sense_exit) begin
          state_d = S_IDLE;
          retry_d = 2'd0;
        end else if (pay_valid && pay_ok) begin
          state_d = S_OPEN;
          tcnt_d  = 4'd0;
        end else if (pay_valid || (tcnt_q == WAIT_LAST)) begin
          state_d = S_DENY;
          retry_d = retry_q + 2'd1;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      S_DENY: begin
        if (retry_q == RETRY_MAX) begin
          state_d = S_LOCK;
        end else begin
          state_d = S_VERIFY;
          tcnt_d  = 4'd0;
        end
      end
      S_OPEN: begin
        if (sense_clear || (tcnt_q == OPEN_LAST)) begin
          state_d = S_IDLE;
          retry_d = 2'd0;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      S_LOCK:  state_d = S_LOCK;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gate_d  = 1'b0;
    green_d = 1'b0;
    red_d   = 1'b0;
    alarm_d = 1'b0;
    hex1_d  = SEG_OFF;
    hex2_d  = SEG_OFF;
    case (state_d)
      S_VERIFY: begin
        green_d = 1'b1;
        hex1_d  = SEG_P;
        hex2_d  = SEG_A;
      end
      S_OPEN: begin
        gate_d  = 1'b1;
        green_d = 1'b1;
        hex1_d  = SEG_G;
        hex2_d  = SEG_O;
      end
      S_DENY: begin
        red_d  = 1'b1;
        hex1_d = SEG_E;
        hex2_d = SEG_E;
      end
      S_LOCK: begin
        red_d   = 1'b1;
        alarm_d = 1'b1;
        hex1_d  = SEG_S;
        hex2_d  = SEG_P;
      end
      default: ;
    endcase
  end

  assign gate_open       = gate_q;
  assign green_light     = green_q;
  assign red_light       = red_q;
  assign alarm           = alarm_q;
  assign hex_1           = hex1_q;
  assign hex_2           = hex2_q;
  assign exit_done       = exit_q;
  assign count_cars      = count_q;
  assign space_available = space_q;

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed scenarios followed by random traffic, each cycle compared against a
// behavioural model of the exit gate and occupancy rules.
module tb_parking_exit_controller;

  localparam int CAP      = 8;
  localparam int WAITN    = 4;
  localparam int OPEN_TO  = 8;
  localparam int MAXR     = 3;
  localparam logic [1:0] CODE = 2'b10;

  logic       clk = 1'b0;
  logic       rst, sense_exit, sense_clear, pay_valid, car_entered;
  logic [1:0] pay_1, pay_2;
  logic       gate_open, green_light, red_light, alarm, exit_done;
  logic [6:0] hex_1, hex_2;
  logic [3:0] count_cars, space_available;

  int passed = 0;
  int total  = 0;

  parking_exit_controller dut (
    .clk(clk), .rst(rst), .sense_exit(sense_exit), .sense_clear(sense_clear),
    .pay_valid(pay_valid), .pay_1(pay_1), .pay_2(pay_2), .car_entered(car_entered),
    .gate_open(gate_open), .green_light(green_light), .red_light(red_light),
    .alarm(alarm), .hex_1(hex_1), .hex_2(hex_2), .exit_done(exit_done),
    .count_cars(count_cars), .space_available(space_available)
  );

  always #5 clk = ~clk;

  // Reference model: phase name, cycles still allowed in the phase, failures so far.
  typedef enum {M_IDLE, M_VERIFY, M_OPEN, M_DENY, M_LOCK} phase_t;
  phase_t m_phase = M_IDLE;
  int m_left  = 0;
  int m_fails = 0;
  int m_cars  = 0;
  bit m_exit  = 0;

  task automatic model_step();
    bit confirmed;
    if (rst) begin
      m_phase = M_IDLE; m_left = 0; m_fails = 0; m_cars = 0; m_exit = 0;
      return;
    end
    confirmed = (m_phase == M_OPEN) && sense_clear;
    m_exit = confirmed;
    if (car_entered && !(confirmed && m_cars > 0)) m_cars = (m_cars < CAP) ? m_cars + 1 : m_cars;
    else if (confirmed && !(car_entered && m_cars < CAP)) m_cars = (m_cars > 0) ? m_cars - 1 : 0;
    case (m_phase)
      M_IDLE: if (sense_exit && m_cars_before_ok()) begin m_phase = M_VERIFY; m_left = WAITN; end
      M_VERIFY: begin
        if (!sense_exit) begin m_phase = M_IDLE; m_fails = 0; end
        else if (pay_valid && pay_1 == CODE && pay_2 == CODE) begin m_phase = M_OPEN; m_left = OPEN_TO; end
        else if (pay_valid || m_left == 1) begin m_phase = M_DENY; m_fails++; end
        else m_left--;
      end
      M_DENY: if (m_fails >= MAXR) m_phase = M_LOCK;
              else begin m_phase = M_VERIFY; m_left = WAITN; end
      M_OPEN: begin
        if (sense_clear || m_left == 1) begin m_phase = M_IDLE; m_fails = 0; end
        else m_left--;
      end
      default: m_phase = M_LOCK;
    endcase
  endtask

  // Occupancy seen by the IDLE decision is the count before this edge's update.
  int m_cars_prev = 0;
  function automatic bit m_cars_before_ok();
    return m_cars_prev > 0;
  endfunction

  function automatic logic [26:0] model_outputs();
    logic g, gr, r, a;
    logic [6:0] h1, h2;
    logic [3:0] cars, space;
    {g, gr, r, a} = 4'b0000; h1 = 7'b0; h2 = 7'b0;
    case (m_phase)
      M_VERIFY: begin gr = 1; h1 = 7'b1110011; h2 = 7'b1110111; end
      M_OPEN:   begin g = 1; gr = 1; h1 = 7'b1111101; h2 = 7'b0111111; end
      M_DENY:   begin r = 1; h1 = 7'b1111001; h2 = 7'b1111001; end
      M_LOCK:   begin r = 1; a = 1; h1 = 7'b1101101; h2 = 7'b1110011; end
      default: ;
    endcase
    cars  = 4'(m_cars);
    space = 4'(CAP - m_cars);
    return {g, gr, r, a, h1, h2, m_exit, cars, space};
  endfunction

  task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    m_cars_prev = m_cars;
    model_step();
    @(negedge clk);
    check("cycle", {gate_open, green_light, red_light, alarm, hex_1, hex_2,
                    exit_done, count_cars, space_available}, model_outputs());
  endtask

  task automatic drive(input bit se, input bit sc, input bit pv,
                       input logic [1:0] p1, input logic [1:0] p2, input bit ce);
    sense_exit = se; sense_clear = sc; pay_valid = pv; pay_1 = p1; pay_2 = p2; car_entered = ce;
  endtask

  task automatic enter_cars(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 2'b00, 2'b00, 1); tick();
      drive(0, 0, 0, 2'b00, 2'b00, 0); tick();
    end
  endtask

  initial begin
    rst = 1; drive(0, 0, 0, 2'b00, 2'b00, 0);
    @(negedge clk);
    tick(); tick();
    check("reset_space", 27'(space_available), 27'(CAP));
    rst = 0;

    // Normal exit with code in the second VERIFY cycle
    enter_cars(3);
    check("t1_count3", 27'(count_cars), 27'd3);
    drive(1, 0, 0, 2'b00, 2'b00, 0); tick();
    tick();
    drive(1, 0, 1, CODE, CODE, 0); tick();
    check("t1_gate_open", 27'(gate_open), 27'd1);
    drive(1, 0, 0, 2'b00, 2'b00, 0); tick();
    drive(1, 1, 0, 2'b00, 2'b00, 0); tick();
    check("t1_exit_done", 27'({exit_done, gate_open, count_cars, space_available}), 27'({1'b1, 1'b0, 4'd2, 4'd6}));
    drive(0, 0, 0, 2'b00, 2'b00, 0); tick();
    check("t1_exit_pulse_end", 27'(exit_done), 27'd0);

    // Empty lot ignores a waiting car
    rst = 1; tick(); rst = 0;
    drive(1, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 10; i++) tick();
    check("t2_empty_idle", 27'({gate_open, green_light}), 27'd0);

    // Three wrong codes lock the gate
    enter_cars(2);
    drive(1, 0, 0, 2'b00, 2'b00, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 2'b01, CODE, 0); tick();
      check("t3_deny", 27'({red_light, hex_1, hex_2}), 27'({1'b1, 7'b1111001, 7'b1111001}));
      drive(1, 0, 0, 2'b00, 2'b00, 0); tick();
    end
    check("t3_lock_alarm", 27'(alarm), 27'd1);
    drive(1, 0, 1, CODE, CODE, 0); tick(); tick();
    check("t3_lock_holds", 27'({alarm, gate_open}), 27'b10);
    rst = 1; tick(); rst = 0;
    check("t3_reset_count", 27'({count_cars, alarm}), 27'd0);

    // Timeout counts as a failure; a later exit clears the retries
    enter_cars(2);
    drive(1, 0, 0, 2'b00, 2'b00, 0); tick();
    for (int i = 0; i < 3; i++) tick();
    check("t4_still_verify", 27'(green_light), 27'd1);
    tick();
    check("t4_timeout_deny", 27'(red_light), 27'd1);
    tick();
    drive(1, 0, 1, CODE, CODE, 0); tick();
    drive(1, 1, 0, 2'b00, 2'b00, 0); tick();
    drive(1, 0, 0, 2'b00, 2'b00, 0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 2'b11, 2'b11, 0); tick();
      drive(1, 0, 0, 2'b00, 2'b00, 0); tick();
    end
    check("t4_no_lock", 27'({alarm, green_light}), 27'b01);
    drive(0, 0, 0, 2'b00, 2'b00, 0); tick();

    // Barrier times out without a car passing
    drive(1, 0, 0, 2'b00, 2'b00, 0); tick();
    drive(1, 0, 1, CODE, CODE, 0); tick();
    drive(0, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 7; i++) tick();
    check("t5_open_7", 27'(gate_open), 27'd1);
    tick();
    check("t5_timeout", 27'({gate_open, exit_done, count_cars}), 27'({1'b0, 1'b0, 4'd1}));

    // Entry coincident with exit, then saturation
    drive(1, 0, 0, 2'b00, 2'b00, 0); tick();
    drive(1, 0, 1, CODE, CODE, 0); tick();
    drive(1, 1, 0, 2'b00, 2'b00, 1); tick();
    check("t6_inc_dec", 27'({exit_done, count_cars}), 27'({1'b1, 4'd1}));
    enter_cars(9);
    check("t6_saturate", 27'({count_cars, space_available}), 27'({4'd8, 4'd0}));

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) ? CODE : 2'($urandom), $urandom_range(0, 1) ? CODE : 2'($urandom),
            $urandom_range(0, 3) == 0);
      tick();
    end
    rst = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
